// File: rtl/tagged_regfile_if.sv
// tagged_regfile_if -- bundle of the rename/broadcast/read signals for tagged_regfile.
//
// Signals (named from the register file's point of view):
//   ReadAddr   NRD*ADDR_W  packed read addresses, port i in slice i
//   DataOut    NRD*DATA_W  packed read data (combinational)
//   LabelOut   NRD*TAG_W   packed read labels (combinational)
//   RegWr      1           rename strobe
//   WriteAddr  ADDR_W      register being renamed
//   WriteLabel TAG_W       new pending label
//   BCEN       NBC         per-channel broadcast valid
//   BClabel    NBC*TAG_W   packed broadcast labels
//   BCdata     NBC*DATA_W  packed broadcast data
//   Flush      1           drop every pending label
//   PendCnt    ADDR_W+1    registered count of registers with a nonzero label
//
// Modports: master drives requests and observes results; slave is the register file.
interface tagged_regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int TAG_W  = 5,
    parameter int NRD    = 2,
    parameter int NBC    = 2
);
    logic [NRD*ADDR_W-1:0] ReadAddr;
    logic [NRD*DATA_W-1:0] DataOut;
    logic [NRD*TAG_W-1:0]  LabelOut;
    logic                  RegWr;
    logic [ADDR_W-1:0]     WriteAddr;
    logic [TAG_W-1:0]      WriteLabel;
    logic [NBC-1:0]        BCEN;
    logic [NBC*TAG_W-1:0]  BClabel;
    logic [NBC*DATA_W-1:0] BCdata;
    logic                  Flush;
    logic [ADDR_W:0]       PendCnt;

    modport master (
        output ReadAddr, RegWr, WriteAddr, WriteLabel, BCEN, BClabel, BCdata, Flush,
        input  DataOut, LabelOut, PendCnt
    );

    modport slave (
        input  ReadAddr, RegWr, WriteAddr, WriteLabel, BCEN, BClabel, BCdata, Flush,
        output DataOut, LabelOut, PendCnt
    );
endinterface

// File: rtl/tagged_regfile.sv
// tagged_regfile -- register file with reservation-station labels for a
// Tomasulo-style core. Each register holds data plus a label; a nonzero label
// means the value is still being produced and will arrive on a broadcast
// (CDB) channel carrying that label. Register 0 is hardwired to data 0, label 0.
//
// Ports:
//   clk   single clock, all state updates on the rising edge
//   nRST  asynchronous active-low reset, clears all data, labels and PendCnt
//   bus   tagged_regfile_if.slave (reads, rename, broadcast, flush, PendCnt)
//
// Configuration macro REGFILE_BYPASS_EN: when defined, a read of a register
// whose label matches an active broadcast this cycle returns the broadcast
// data with label 0 in the same cycle. When undefined, reads show stored
// state only.
module tagged_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int TAG_W  = 5,
    parameter int NRD    = 2,
    parameter int NBC    = 2
) (
    input logic            clk,
    input logic            nRST,
    tagged_regfile_if.slave bus
);
    localparam int NREG = 2**ADDR_W;

    logic [DATA_W-1:0] dataMem   [NREG];
    logic [TAG_W-1:0]  labelMem  [NREG];
    logic [DATA_W-1:0] nextData  [NREG];
    logic [TAG_W-1:0]  nextLabel [NREG];
    logic [ADDR_W:0]   nextPend;
    logic [ADDR_W:0]   pendCnt;
    logic [DATA_W-1:0] capData;

    // Returns 1 when an active channel carries this (nonzero) label. Channels
    // are scanned high to low so the lowest-index match is the one kept.
    // A zero label never matches, which also discards broadcasts of label 0.
    function automatic logic bcLookup(
        input  logic [TAG_W-1:0]      label,
        input  logic [NBC-1:0]        en,
        input  logic [NBC*TAG_W-1:0]  labels,
        input  logic [NBC*DATA_W-1:0] datas,
        output logic [DATA_W-1:0]     data
    );
        logic hit;
        hit  = 1'b0;
        data = '0;
        for (int c = NBC - 1; c >= 0; c--) begin
            if (en[c] && label != '0 && labels[c*TAG_W +: TAG_W] == label) begin
                hit  = 1'b1;
                data = datas[c*DATA_W +: DATA_W];
            end
        end
        return hit;
    endfunction

    // Next-state for every register. Order of precedence on the label:
    // flush, then rename, then broadcast capture. Data only ever changes
    // through a broadcast capture, whatever happens to the label.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write,
        // so no path leaves it unassigned and no latch is inferred.
        nextPend = '0;
        capData  = '0;
        for (int r = 0; r < NREG; r++) begin
            nextData[r]  = dataMem[r];
            nextLabel[r] = labelMem[r];
            if (r == 0) begin
                nextData[r]  = '0;
                nextLabel[r] = '0;
            end else begin
                if (bcLookup(labelMem[r], bus.BCEN, bus.BClabel, bus.BCdata, capData)) begin
                    nextData[r]  = capData;
                    nextLabel[r] = '0;
                end
                if (bus.Flush) begin
                    nextLabel[r] = '0;
                end else if (bus.RegWr && bus.WriteAddr == ADDR_W'(r)) begin
                    nextLabel[r] = bus.WriteLabel;
                end
            end
            if (nextLabel[r] != '0) begin
                nextPend = nextPend + (ADDR_W+1)'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // sees the pre-edge values of the others within the same edge.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            // NOTE: the storage array is reset explicitly because reset must
            // clear every register's data and label, not just the control state;
            // this keeps it in flops rather than a RAM macro.
            for (int r = 0; r < NREG; r++) begin
                dataMem[r]  <= '0;
                labelMem[r] <= '0;
            end
            pendCnt <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                dataMem[r]  <= nextData[r];
                labelMem[r] <= nextLabel[r];
            end
            pendCnt <= nextPend;
        end
    end

    assign bus.PendCnt = pendCnt;

    // Read ports. With NREG = 2**ADDR_W every address decodes to a register,
    // and duplicate addresses simply select the same storage.
    for (genvar i = 0; i < NRD; i++) begin : gRead
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] rdData;
        logic [TAG_W-1:0]  rdLabel;

        assign addr = bus.ReadAddr[i*ADDR_W +: ADDR_W];

`ifdef REGFILE_BYPASS_EN
        logic [DATA_W-1:0] byData;
        logic              byHit;

        // Forward the winning broadcast to a reader still waiting on it. A
        // same-cycle rename is not visible here: the stored label is used.
        always_comb begin
            byData  = '0;
            byHit   = bcLookup(labelMem[addr], bus.BCEN, bus.BClabel, bus.BCdata, byData);
            rdData  = byHit ? byData : dataMem[addr];
            rdLabel = byHit ? '0 : labelMem[addr];
        end
`else
        assign rdData  = dataMem[addr];
        assign rdLabel = labelMem[addr];
`endif

        assign bus.DataOut[i*DATA_W +: DATA_W]  = rdData;
        assign bus.LabelOut[i*TAG_W +: TAG_W]   = rdLabel;
    end

endmodule

// File: tb/tb_tagged_regfile.sv
// tb_tagged_regfile -- directed bench for tagged_regfile with a scoreboard.
// Stimulus pushes the expected read/PendCnt values for a cycle into a queue and
// raises obsValid; an independent monitor pops and compares on the falling edge.
// Compile with +define+REGFILE_BYPASS_EN to check the bypass build.
module tb_tagged_regfile;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int TAG_W  = 5;
    localparam int NRD    = 2;
    localparam int NBC    = 2;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [31:0] d0;
        logic [4:0]  l0;
        logic [31:0] d1;
        logic [4:0]  l1;
        logic [5:0]  pend;
    } expT;

    logic clk;
    logic nRST;
    logic obsValid;
    expT  expQ[$];
    int   checks;
    int   errors;

    tagged_regfile_if #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TAG_W(TAG_W), .NRD(NRD), .NBC(NBC)
    ) bus ();

    tagged_regfile #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TAG_W(TAG_W), .NRD(NRD), .NBC(NBC)
    ) dut (
        .clk (clk),
        .nRST(nRST),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input string field,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s got 0x%0h expected 0x%0h", name, field, act, exp);
        end
    endtask

    // Monitor: compares the DUT against the oldest queued expectation.
    always @(negedge clk) begin
        if (obsValid) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard observation with empty expectation queue");
            end else begin
                expT e;
                e = expQ.pop_front();
                check(e.name, "DataOut0",  bus.DataOut[31:0],          e.d0);
                check(e.name, "LabelOut0", {27'd0, bus.LabelOut[4:0]}, {27'd0, e.l0});
                check(e.name, "DataOut1",  bus.DataOut[63:32],         e.d1);
                check(e.name, "LabelOut1", {27'd0, bus.LabelOut[9:5]}, {27'd0, e.l1});
                check(e.name, "PendCnt",   {26'd0, bus.PendCnt},       {26'd0, e.pend});
            end
        end
    end

    task automatic idle();
        bus.RegWr      = 1'b0;
        bus.WriteAddr  = '0;
        bus.WriteLabel = '0;
        bus.BCEN       = '0;
        bus.BClabel    = '0;
        bus.BCdata     = '0;
        bus.Flush      = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        obsValid = 1'b0;
    endtask

    task automatic rename(input logic [4:0] addr, input logic [4:0] label);
        bus.RegWr      = 1'b1;
        bus.WriteAddr  = addr;
        bus.WriteLabel = label;
    endtask

    task automatic bcast(input logic [1:0] en, input logic [4:0] lab0, input logic [31:0] dat0,
                         input logic [4:0] lab1, input logic [31:0] dat1);
        bus.BCEN    = en;
        bus.BClabel = {lab1, lab0};
        bus.BCdata  = {dat1, dat0};
    endtask

    // Set the read addresses for this cycle and queue what they must show.
    task automatic expectObs(input string name, input logic [4:0] a0, input logic [4:0] a1,
                             input logic [31:0] d0, input logic [4:0] l0,
                             input logic [31:0] d1, input logic [4:0] l1,
                             input logic [5:0] pend);
        expT e;
        bus.ReadAddr = {a1, a0};
        e.name = name;
        e.d0 = d0; e.l0 = l0; e.d1 = d1; e.l1 = l1; e.pend = pend;
        expQ.push_back(e);
        obsValid = 1'b1;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        obsValid     = 1'b0;
        nRST         = 1'b0;
        bus.ReadAddr = '0;
        idle();
        tick();
        tick();
        nRST = 1'b1;

        // Reset state
        idle(); expectObs("reset", 5'd1, 5'd2, 0, 0, 0, 0, 0); tick();

        // Rename r2 -> 3, then broadcast label 3 data 10
        idle(); rename(5'd2, 5'd3); tick();
        idle(); bcast(2'b01, 5'd3, 32'd10, 5'd0, 32'd0);
        expectObs("bc_cycle", 5'd2, 5'd2, BYP ? 32'd10 : 32'd0, BYP ? 5'd0 : 5'd3,
                  BYP ? 32'd10 : 32'd0, BYP ? 5'd0 : 5'd3, 1);
        tick();
        idle(); expectObs("bc_after", 5'd2, 5'd1, 10, 0, 0, 0, 0); tick();

        // r4, r5 both wait on label 7; channel 1 delivers; channel 0 has label 0
        idle(); rename(5'd4, 5'd7); tick();
        idle(); rename(5'd5, 5'd7);
        expectObs("ren_r4", 5'd4, 5'd5, 0, 7, 0, 0, 1); tick();
        idle(); bcast(2'b11, 5'd0, 32'h99, 5'd7, 32'hABCD);
        expectObs("bc_two", 5'd4, 5'd5, BYP ? 32'hABCD : 32'd0, BYP ? 5'd0 : 5'd7,
                  BYP ? 32'hABCD : 32'd0, BYP ? 5'd0 : 5'd7, 2);
        tick();
        idle(); expectObs("bc_two_after", 5'd4, 5'd5, 32'hABCD, 0, 32'hABCD, 0, 0); tick();

        // Rename and capture on r6 in the same cycle: data 55, label 9
        idle(); rename(5'd6, 5'd2); tick();
        idle(); rename(5'd6, 5'd9); bcast(2'b01, 5'd2, 32'd55, 5'd0, 32'd0);
        expectObs("ren_bc", 5'd6, 5'd6, BYP ? 32'd55 : 32'd0, BYP ? 5'd0 : 5'd2,
                  BYP ? 32'd55 : 32'd0, BYP ? 5'd0 : 5'd2, 1);
        tick();
        idle(); expectObs("ren_bc_after", 5'd6, 5'd1, 55, 9, 0, 0, 1); tick();

        // Rename with label 0 clears the label, data kept
        idle(); rename(5'd6, 5'd0); tick();
        idle(); expectObs("ren_zero", 5'd6, 5'd2, 55, 0, 10, 0, 0); tick();

        // Rename r1..r31 with labels 1..31
        for (int r = 1; r < 32; r++) begin
            idle(); rename(5'(r), 5'(r)); tick();
        end
        // Flush: rename r3 is overridden, broadcast label 6 still captured into r6
        idle(); bus.Flush = 1'b1; rename(5'd3, 5'd5); bcast(2'b01, 5'd6, 32'h77, 5'd0, 32'd0);
        expectObs("all_pend", 5'd2, 5'd4, 10, 2, 32'hABCD, 4, 31);
        tick();
        idle(); rename(5'd0, 5'd4);
        expectObs("flushed", 5'd0, 5'd3, 0, 0, 0, 0, 0); tick();
        idle(); expectObs("r0_ignored", 5'd6, 5'd4, 32'h77, 0, 32'hABCD, 0, 0); tick();
        idle(); expectObs("r0_read", 5'd0, 5'd0, 0, 0, 0, 0, 0); tick();

        // Both channels carry label 6: channel 0 (data 1) wins
        idle(); rename(5'd3, 5'd6); tick();
        idle(); bcast(2'b11, 5'd6, 32'd1, 5'd6, 32'd2);
        expectObs("bc_prio", 5'd3, 5'd3, BYP ? 32'd1 : 32'd0, BYP ? 5'd0 : 5'd6,
                  BYP ? 32'd1 : 32'd0, BYP ? 5'd0 : 5'd6, 1);
        tick();
        idle(); expectObs("bc_prio_after", 5'd3, 5'd5, 1, 0, 32'hABCD, 0, 0); tick();

        // Reset mid-cycle with rename and broadcast active
        idle(); rename(5'd7, 5'd8); tick();
        idle(); rename(5'd8, 5'd9); bcast(2'b01, 5'd8, 32'h123, 5'd0, 32'd0);
        #1;
        nRST = 1'b0;
        expectObs("async_rst", 5'd7, 5'd4, 0, 0, 0, 0, 0);
        tick();
        tick();
        idle();
        nRST = 1'b1;
        expectObs("post_rst", 5'd8, 5'd6, 0, 0, 0, 0, 0); tick();
        idle(); expectObs("post_rst2", 5'd7, 5'd4, 0, 0, 0, 0, 0); tick();

        // Drain: every queued expectation must have been consumed.
        for (int i = 0; i < 10 && expQ.size() != 0; i++) @(negedge clk);
        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain %0d expectations never observed, required 0", expQ.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout reached before end of stimulus");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tagged_regfile.md
TAGGED_REGFILE -- requirements
Module: tagged_regfile

Interface
REQ-001 Parameter DATA_W, default 32, register data width.
REQ-002 Parameter ADDR_W, default 5, register address width; NREG = 2**ADDR_W registers.
REQ-003 Parameter TAG_W, default 5, label (reservation-station tag) width; label 0 means "value valid, nothing pending".
REQ-004 Parameter NRD, default 2, number of read ports.
REQ-005 Parameter NBC, default 2, number of broadcast (CDB) channels.
REQ-006 clk  in  1  single clock; all state updates on the rising edge.
REQ-007 nRST  in  1  reset, asynchronous, active-low.
REQ-008 ReadAddr  in  NRD*ADDR_W  packed read addresses; port i uses slice i.
REQ-009 DataOut  out  NRD*DATA_W  packed read data, combinational.
REQ-010 LabelOut  out  NRD*TAG_W  packed read labels, combinational.
REQ-011 RegWr  in  1  rename strobe: attach WriteLabel to WriteAddr.
REQ-012 WriteAddr  in  ADDR_W  register being renamed.
REQ-013 WriteLabel  in  TAG_W  new pending label.
REQ-014 BCEN  in  NBC  per-channel broadcast valid.
REQ-015 BClabel  in  NBC*TAG_W  packed broadcast labels.
REQ-016 BCdata  in  NBC*DATA_W  packed broadcast data.
REQ-017 Flush  in  1  clear all pending labels (misprediction recovery).
REQ-018 PendCnt  out  ADDR_W+1  registered count of registers with nonzero label.

Function
REQ-019 Each register holds Data[DATA_W] and Label[TAG_W]; register 0 SHALL always read Data 0, Label 0 and ignore renames and broadcasts.
REQ-020 Broadcast capture: on each edge, for every register r!=0 with Label[r]!=0 and channel c active (BCEN[c]=1, BClabel[c]=Label[r]), Data[r] <= BCdata[c], Label[r] <= 0.
REQ-021 BCEN[c] with BClabel[c]=0 SHALL be ignored.
REQ-022 Multiple active channels carrying the same label: lowest channel index wins.
REQ-023 Rename: RegWr=1 and WriteAddr!=0 SHALL set Label[WriteAddr] <= WriteLabel at the edge; Data unchanged unless REQ-024 applies.
REQ-024 Rename and matching broadcast to the same register in one cycle: Data takes broadcast data, Label takes WriteLabel (rename wins).
REQ-025 RegWr with WriteLabel=0 SHALL clear the label without changing Data.
REQ-026 Flush=1: all labels <= 0, Data unchanged; broadcasts in that cycle still update Data; Flush overrides rename in that cycle.
REQ-027 Reads combinational: DataOut[i]/LabelOut[i] reflect stored state of ReadAddr[i] except as modified by REQ-033.
REQ-028 PendCnt SHALL equal the number of nonzero labels after each edge; maximum NREG-1, never wraps.
REQ-029 Out-of-range or duplicate read addresses SHALL be legal; duplicate ports return identical values.

Reset
REQ-030 nRST=0 SHALL immediately clear every Data and Label to 0 and PendCnt to 0, independent of clk.
REQ-031 After nRST deasserts, first state update occurs on the next rising clk edge; inputs during reset are ignored.
REQ-032 Reset asserted mid-cycle with RegWr/BCEN active: the pending update is lost; state stays 0.

Configuration
REQ-033 Macro REGFILE_BYPASS_EN defined: a read port whose register has Label!=0 matching an active broadcast this cycle SHALL output DataOut=BCdata (winning channel per REQ-022) and LabelOut=0 in the same cycle; a same-cycle rename to that register is not bypassed (reads show pre-edge label).
REQ-034 Macro REGFILE_BYPASS_EN undefined: read outputs show stored state only; broadcast data becomes visible the cycle after capture.

Verification
REQ-035 Reset then read r1,r2 -> DataOut 0/0, LabelOut 0/0, PendCnt 0.
REQ-036 RegWr r2 label 3, next cycle BCEN[0] label 3 data 10, read r2 -> after second edge Data 10 Label 0, PendCnt 1->0; with REGFILE_BYPASS_EN DataOut=10 LabelOut=0 already during broadcast cycle.
REQ-037 Rename r4 label 7 and r5 label 7, BCEN[1] label 7 data 0xABCD -> both r4,r5 Data 0xABCD Label 0, PendCnt 2->0.
REQ-038 r6 pending label 2; same cycle RegWr r6 label 9 and BCEN[0] label 2 data 55 -> r6 Data 55 Label 9, PendCnt stays 1.
REQ-039 Rename r1..r31 labels 1..31 -> PendCnt 31; Flush=1 -> all labels 0, PendCnt 0, data unchanged; RegWr r0 label 4 -> r0 label stays 0.
REQ-040 BCEN=2'b11 both label 6 data 1 and 2, r3 pending label 6 -> r3 Data 1; nRST pulse mid-cycle -> all state 0 immediately.
